muldiv_iter: RTL and testbench

Iterative RV64M multiply/divide unit in the execute stage, downstream of the ALU operand selector. It consumes the selected operands `alu_a`/`alu_b` for M-extension instructions and returns a 64-bit result after a fixed multi-cycle latency. While it works, it holds the pipeline through `busy` and `done`. It implements MUL, DIV, DIVU, REM and REMU, plus their W (32-bit) forms.

---
 rtl/muldiv_iter.sv | 198 +++++++++++++++++++
 tb/tb_muldiv_iter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_iter
//  Description : Iterative RV64M multiply/divide unit. One multiplier bit or
//                one quotient bit per clock, fixed latency of XLEN+1 cycles
//                from acceptance to the done pulse. Supports MUL, DIV, DIVU,
//                REM, REMU and their W (32-bit) forms.
//  Ports       : clk    - clock, rising edge
//                reset  - asynchronous active-high reset
//                valid  - start request, sampled only in IDLE
//                a, b   - operands (dividend/multiplicand, divisor/multiplier)
//                op     - 000 MUL, 001 DIV, 010 DIVU, 011 REM, 100 REMU
//                word   - W variant (32-bit operands, sign-extended result)
//                flush  - abort current operation, return to IDLE
//                busy   - high in RUN and DONE
//                done   - one-cycle pulse, result valid while high
//                result - operation result, held until the next DONE
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int              c_CNT_W    = $clog2(XLEN);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(XLEN - 1);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_RUN  = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    localparam logic [2:0] c_OP_DIV  = 3'd1;
    localparam logic [2:0] c_OP_DIVU = 3'd2;
    localparam logic [2:0] c_OP_REM  = 3'd3;
    localparam logic [2:0] c_OP_REMU = 3'd4;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_is_div;   // any divide/remainder op
    logic               r_is_rem;   // remainder is the requested result
    logic               r_word;
    logic               r_qneg;
    logic               r_rneg;
    // r_x: multiplicand (MUL) or dividend shifting out / quotient shifting in
    // r_y: multiplier (MUL) or divisor magnitude
    // r_acc: product accumulator (MUL) or partial remainder (DIV)
    logic [XLEN-1:0]    r_x;
    logic [XLEN-1:0]    r_y;
    logic [XLEN-1:0]    r_acc;
    logic [XLEN-1:0]    r_result;

    // ---------------- operand preparation at acceptance ----------------
    logic            w_in_div;
    logic            w_in_sgn;
    logic            w_in_uns;
    logic [XLEN-1:0] w_a_prep;
    logic [XLEN-1:0] w_b_prep;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_accept;

    assign w_in_sgn = (op == c_OP_DIV)  || (op == c_OP_REM);
    assign w_in_uns = (op == c_OP_DIVU) || (op == c_OP_REMU);
    assign w_in_div = w_in_sgn || w_in_uns;

    // W forms: zero-extend only for the unsigned divides, sign-extend otherwise
    assign w_a_prep = !word   ? a :
                      w_in_uns ? {{(XLEN-32){1'b0}}, a[31:0]} :
                                 {{(XLEN-32){a[31]}}, a[31:0]};
    assign w_b_prep = !word   ? b :
                      w_in_uns ? {{(XLEN-32){1'b0}}, b[31:0]} :
                                 {{(XLEN-32){b[31]}}, b[31:0]};

    assign w_a_mag = (w_in_sgn && w_a_prep[XLEN-1]) ? -w_a_prep : w_a_prep;
    assign w_b_mag = (w_in_sgn && w_b_prep[XLEN-1]) ? -w_b_prep : w_b_prep;

    assign w_accept = (r_state == c_S_IDLE) && valid && !flush;

    // ---------------- one iteration step ----------------
    logic [XLEN-1:0] w_mul_acc;
    logic [XLEN:0]   w_rem_sh;    // 65-bit partial remainder after the shift
    logic [XLEN+1:0] w_diff;
    logic            w_qbit;
    logic [XLEN-1:0] w_rem_nxt;
    logic [XLEN-1:0] w_quo_nxt;
    logic            w_unused;

    assign w_mul_acc = r_acc + (r_y[0] ? r_x : '0);

    assign w_rem_sh  = {r_acc, r_x[XLEN-1]};
    assign w_diff    = {1'b0, w_rem_sh} - {2'b00, r_y};
    assign w_qbit    = !w_diff[XLEN+1];
    // Remainder stays below the divisor, so the low XLEN bits are sufficient
    assign w_rem_nxt = w_qbit ? w_diff[XLEN-1:0] : w_rem_sh[XLEN-1:0];
    assign w_quo_nxt = {r_x[XLEN-2:0], w_qbit};
    assign w_unused  = w_diff[XLEN];

    // ---------------- result fix-up on the final iteration ----------------
    logic [XLEN-1:0] w_raw;
    logic [XLEN-1:0] w_final;

    always_comb begin
        w_raw = w_mul_acc;
        if (r_is_div) begin
            if (r_is_rem) begin
                w_raw = r_rneg ? -w_rem_nxt : w_rem_nxt;
            end else begin
                w_raw = r_qneg ? -w_quo_nxt : w_quo_nxt;
            end
        end
    end

    assign w_final = r_word ? {{(XLEN-32){w_raw[31]}}, w_raw[31:0]} : w_raw;

    // ---------------- state machine ----------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE: if (valid)                 w_state_nxt = c_S_RUN;
            c_S_RUN:  if (r_cnt == c_CNT_LAST)   w_state_nxt = c_S_DONE;
            c_S_DONE:                            w_state_nxt = c_S_IDLE;
            default:                             w_state_nxt = c_S_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = c_S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_is_rem <= 1'b0;
            r_word   <= 1'b0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_is_div <= w_in_div;
            r_is_rem <= (op == c_OP_REM) || (op == c_OP_REMU);
            r_word   <= word;
            // A zero divisor yields an all-ones quotient: suppress negation.
            // The remainder path then rebuilds the prepared dividend from its
            // magnitude, because restoring division by zero shifts the whole
            // dividend into the remainder.
            r_qneg   <= w_in_sgn && (w_a_prep[XLEN-1] ^ w_b_prep[XLEN-1])
                        && (w_b_prep != '0);
            r_rneg   <= w_in_sgn && w_a_prep[XLEN-1];
            r_x      <= w_in_div ? w_a_mag : w_a_prep;
            r_y      <= w_in_div ? w_b_mag : w_b_prep;
            r_acc    <= '0;
        end else if ((r_state == c_S_RUN) && !flush) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_is_div) begin
                r_x   <= w_quo_nxt;
                r_acc <= w_rem_nxt;
            end else begin
                r_x   <= {r_x[XLEN-2:0], 1'b0};
                r_y   <= {1'b0, r_y[XLEN-1:1]};
                r_acc <= w_mul_acc;
            end
            if (r_cnt == c_CNT_LAST) begin
                r_result <= w_final;
            end
        end
    end

    assign busy   = (r_state != c_S_IDLE);
    assign done   = (r_state == c_S_DONE);
    assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_muldiv_iter
//  Description : Self-checking bench for muldiv_iter. Table of operation
//                vectors with a result scoreboard, plus hand-written flush
//                and asynchronous-reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_iter;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic        word;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        valid;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  op;
    logic        word;
    logic        flush;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int          total;
    int          bad;
    vec_t        vecs[$];
    logic [63:0] exp_q[$];

    muldiv_iter #(.XLEN(64)) dut (
        .clk    (clk),
        .reset  (reset),
        .valid  (valid),
        .a      (a),
        .b      (b),
        .op     (op),
        .word   (word),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, req);
        end
    endtask

    task automatic add_vec(input string n, input logic [2:0] o, input logic w,
                           input logic [63:0] x, input logic [63:0] y, input logic [63:0] e);
        vec_t v;
        v.name = n; v.op = o; v.word = w; v.a = x; v.b = y; v.exp = e;
        vecs.push_back(v);
    endtask

    // Called at a falling edge; returns at a falling edge.
    task automatic run_op(input string nm, input logic [2:0] o, input logic w,
                          input logic [63:0] x, input logic [63:0] y, input logic [63:0] e);
        int          lat;
        int          bcnt;
        logic [63:0] req;
        op = o; word = w; a = x; b = y; valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        #1 valid = 1'b0;
        lat  = 0;
        bcnt = 0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
        req = exp_q.pop_front();
        check({nm, "_latency"}, 64'(lat), 64'd65);
        check({nm, "_result"}, result, req);
        check({nm, "_busy_cycles"}, 64'(bcnt), 64'd65);
        @(negedge clk);
        check({nm, "_idle_after"}, 64'({busy, done}), 64'd0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b1;
        valid = 1'b0;
        flush = 1'b0;
        a     = '0;
        b     = '0;
        op    = 3'd0;
        word  = 1'b0;

        add_vec("mul_7_m3",    3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB);
        add_vec("div_m7_2",    3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        add_vec("rem_m7_2",    3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        add_vec("div_7_m2",    3'd1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD);
        add_vec("rem_7_m2",    3'd3, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1);
        add_vec("divu_100_7",  3'd2, 1'b0, 64'd100, 64'd7, 64'd14);
        add_vec("remu_100_7",  3'd4, 1'b0, 64'd100, 64'd7, 64'd2);
        add_vec("div_by0",     3'd1, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        add_vec("divu_by0",    3'd2, 1'b0, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        add_vec("rem_by0",     3'd3, 1'b0, 64'h1234, 64'd0, 64'h1234);
        add_vec("remu_by0",    3'd4, 1'b0, 64'h1234, 64'd0, 64'h1234);
        add_vec("divw_by0",    3'd1, 1'b1, 64'h8000_0000, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        add_vec("div_ovf",     3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
        add_vec("rem_ovf",     3'd3, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        add_vec("divw_ovf",    3'd1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
        add_vec("remw_ovf",    3'd3, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 64'd0);
        add_vec("mulw_ovf",    3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE);
        add_vec("divuw_max",   3'd2, 1'b1, 64'hFFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        add_vec("divw_100_m7", 3'd1, 1'b1, 64'hAAAA_AAAA_0000_0064, 64'h0000_0000_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF2);
        add_vec("remw_m7_2",   3'd3, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        add_vec("remuw_f_16",  3'd4, 1'b1, 64'hFFFF_FFFF, 64'hABCD_0000_0000_0010, 64'd15);
        add_vec("mul_wide",    3'd0, 1'b0, 64'h1_0000_0001, 64'h1_0000_0001, 64'h0000_0002_0000_0001);
        add_vec("divu_big",    3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF);
        add_vec("op5_as_mul",  3'd5, 1'b0, 64'd6, 64'd7, 64'd42);

        // Reset state, observed without any clock edge
        #1;
        check("reset_busy",   64'(busy), 64'd0);
        check("reset_done",   64'(done), 64'd0);
        check("reset_result", result, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b, vecs[i].exp);
        end

        // Flush a DIV at iteration 30, then issue a MUL the following cycle
        op = 3'd1; word = 1'b0; a = 64'd1000; b = 64'd3; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (29) @(posedge clk);
        @(negedge clk);
        check("flush_busy_before", 64'(busy), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        check("flush_busy_after", 64'(busy), 64'd0);
        check("flush_no_done",    64'(done), 64'd0);
        run_op("mul_after_flush", 3'd0, 1'b0, 64'd6, 64'd7, 64'd42);

        // Asynchronous reset in the middle of RUN
        op = 3'd2; word = 1'b0; a = 64'd100; b = 64'd7; valid = 1'b1;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (20) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("areset_busy",   64'(busy), 64'd0);
        check("areset_done",   64'(done), 64'd0);
        check("areset_result", result, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_op("divu_9_3", 3'd2, 1'b0, 64'd9, 64'd3, 64'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
